// File: rtl/user_grant_access_ctrl_pkg.sv
// Shared types and helpers for the user grant access controller: FSM state
// encoding, timer width sizing and the allow-list lookup.
package user_grant_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANTED = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  // Widest packed allow-list / ID the lookup helper accepts.
  localparam int AUTH_LIST_MAX_W = 256;
  localparam int ID_MAX_W        = 32;

  // One timer width serves both the session and lockout timers, so it is
  // sized for the larger of the two reload values.
  function automatic int timer_w(input int session_cycles, input int lock_cycles);
    int m;
    m = (session_cycles > lock_cycles) ? session_cycles : lock_cycles;
    return $clog2(m + 1);
  endfunction

  // True when id matches any of the num entries packed id_w bits apart in
  // list (entry 0 in the LSBs). Unrolls to a flat OR of comparators.
  function automatic logic is_authorised(input logic [ID_MAX_W-1:0]        id,
                                         input logic [AUTH_LIST_MAX_W-1:0] list,
                                         input int                         num,
                                         input int                         id_w);
    logic [ID_MAX_W-1:0]        mask;
    logic [AUTH_LIST_MAX_W-1:0] sh;
    logic                       hit;
    mask = (id_w >= ID_MAX_W) ? '1 : ((32'd1 << id_w) - 32'd1);
    hit  = 1'b0;
    for (int i = 0; i < ID_MAX_W; i++) begin
      if (i < num) begin
        sh = list >> (i * id_w);
        if ((sh[ID_MAX_W-1:0] & mask) == (id & mask)) hit = 1'b1;
      end
    end
    return hit;
  endfunction

endpackage

// File: rtl/user_grant_access_ctrl_down_counter.sv
// Loadable down counter that stops at zero and flags when it is there.
// Used for both the session timer and the lockout timer.
module uga_down_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  // Load has priority over decrement; decrement never wraps below zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/user_grant_access_ctrl.sv
// Guards a DATA_W-bit register behind an allow-list of user IDs. A grant is
// a bounded, single-owner session; MAX_FAIL consecutive denied requests put
// the block into a timed lockout. All outputs are registered (1-cycle latency).
module user_grant_access_ctrl
  import user_grant_pkg::*;
#(
  parameter int                       DATA_W         = 8,
  parameter int                       ID_W           = 3,
  parameter int                       NUM_AUTH       = 2,
  parameter logic [NUM_AUTH*ID_W-1:0] AUTH_IDS       = {3'h6, 3'h4},
  parameter int                       MAX_FAIL       = 3,
  parameter int                       LOCK_CYCLES    = 16,
  parameter int                       SESSION_CYCLES = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            req_valid,
  input  logic [ID_W-1:0]                 usr_id,
  input  logic                            wr_en,
  input  logic                            rel,
  input  logic [DATA_W-1:0]               data_in,
  output logic [DATA_W-1:0]               data_out,
  output logic                            grant,
  output logic [ID_W-1:0]                 owner_id,
  output logic                            locked,
  output logic                            viol,
  output logic [$clog2(MAX_FAIL+1)-1:0]   fail_cnt,
  output logic [1:0]                      o_dbg_state
);

  localparam int TW = timer_w(SESSION_CYCLES, LOCK_CYCLES);
  localparam int FW = $clog2(MAX_FAIL + 1);

  state_t            r_state;
  logic [DATA_W-1:0] r_data;
  logic [ID_W-1:0]   r_owner;
  logic [FW-1:0]     r_fail;
  logic              r_grant;
  logic              r_locked;
  logic              r_viol;

  logic              w_auth;
  logic              w_is_owner;
  logic [FW-1:0]     w_fail_inc;
  logic              w_lock_hit;
  logic              w_sess_load;
  logic              w_lock_load;
  logic              w_sess_zero;
  logic              w_lock_zero;

  // Request decode shared by the FSM and the timer load strobes.
  assign w_auth      = is_authorised(ID_MAX_W'(usr_id), AUTH_LIST_MAX_W'(AUTH_IDS),
                                     NUM_AUTH, ID_W);
  assign w_is_owner  = (usr_id == r_owner);
  assign w_fail_inc  = r_fail + FW'(1);
  assign w_lock_hit  = (w_fail_inc == FW'(MAX_FAIL));
  assign w_sess_load = (r_state == IDLE) && req_valid && w_auth;
  assign w_lock_load = (r_state == IDLE) && req_valid && !w_auth && w_lock_hit;

  uga_down_counter #(.W(TW)) u_sess_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_sess_load),
    .i_load_val (TW'(SESSION_CYCLES - 1)),
    .i_dec      (r_state == GRANTED),
    .o_zero     (w_sess_zero)
  );

  uga_down_counter #(.W(TW)) u_lock_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_lock_load),
    .i_load_val (TW'(LOCK_CYCLES - 1)),
    .i_dec      (r_state == LOCKED),
    .o_zero     (w_lock_zero)
  );

  // Access FSM with registered outputs. In GRANTED the owner write is taken
  // before the release/expiry exit, so a write in the last session cycle or
  // alongside rel still lands.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_data   <= '0;
      r_owner  <= '0;
      r_fail   <= '0;
      r_grant  <= 1'b0;
      r_locked <= 1'b0;
      r_viol   <= 1'b0;
    end else begin
      r_viol <= 1'b0;
      case (r_state)
        IDLE: begin
          if (wr_en) r_viol <= 1'b1;
          if (req_valid) begin
            if (w_auth) begin
              r_state <= GRANTED;
              r_grant <= 1'b1;
              r_owner <= usr_id;
              r_fail  <= '0;
            end else begin
              r_fail <= w_fail_inc;
              if (w_lock_hit) begin
                r_state  <= LOCKED;
                r_locked <= 1'b1;
              end
            end
          end
        end
        GRANTED: begin
          if (wr_en) begin
            if (w_is_owner) r_data <= data_in;
            else            r_viol <= 1'b1;
          end
          if (rel && !w_is_owner) r_viol <= 1'b1;
          if ((rel && w_is_owner) || w_sess_zero) begin
            r_state <= IDLE;
            r_grant <= 1'b0;
            r_owner <= '0;
          end
        end
        LOCKED: begin
          if (wr_en) r_viol <= 1'b1;
          r_fail <= FW'(MAX_FAIL);
          if (w_lock_zero) begin
            r_state  <= IDLE;
            r_locked <= 1'b0;
            r_fail   <= '0;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_grant  <= 1'b0;
          r_locked <= 1'b0;
          r_owner  <= '0;
        end
      endcase
    end
  end

  assign data_out    = r_data;
  assign grant       = r_grant;
  assign owner_id    = r_owner;
  assign locked      = r_locked;
  assign viol        = r_viol;
  assign fail_cnt    = r_fail;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_user_grant_access_ctrl.sv
// Directed, table-driven bench for user_grant_access_ctrl plus hand-written
// sequences for the allow-list sweep and the one-cycle-session variant.
module tb_user_grant_access_ctrl;

  localparam logic [5:0] AUTH = {3'h6, 3'h4};

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT (default parameters)
  logic       rst_n = 1'b0, req_valid = 1'b0, wr_en = 1'b0, rel = 1'b0;
  logic [2:0] usr_id = '0;
  logic [7:0] data_in = '0;
  logic [7:0] data_out;
  logic       grant, locked, viol;
  logic [2:0] owner_id;
  logic [1:0] fail_cnt;
  logic [1:0] dbg_state;

  user_grant_access_ctrl #(
    .DATA_W(8), .ID_W(3), .NUM_AUTH(2), .AUTH_IDS(AUTH),
    .MAX_FAIL(3), .LOCK_CYCLES(16), .SESSION_CYCLES(8)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .usr_id(usr_id),
    .wr_en(wr_en), .rel(rel), .data_in(data_in), .data_out(data_out),
    .grant(grant), .owner_id(owner_id), .locked(locked), .viol(viol),
    .fail_cnt(fail_cnt), .o_dbg_state(dbg_state)
  );

  // Second DUT with a one-cycle session
  logic       d_rst_n = 1'b0, d_req = 1'b0, d_wr = 1'b0, d_rel = 1'b0;
  logic [2:0] d_id = '0;
  logic [7:0] d_din = '0;
  logic [7:0] d_dout;
  logic       d_grant, d_locked, d_viol;
  logic [2:0] d_owner;
  logic [1:0] d_fail;
  logic [1:0] d_state;

  user_grant_access_ctrl #(
    .DATA_W(8), .ID_W(3), .NUM_AUTH(2), .AUTH_IDS(AUTH),
    .MAX_FAIL(3), .LOCK_CYCLES(16), .SESSION_CYCLES(1)
  ) u_dut1 (
    .clk(clk), .rst_n(d_rst_n), .req_valid(d_req), .usr_id(d_id),
    .wr_en(d_wr), .rel(d_rel), .data_in(d_din), .data_out(d_dout),
    .grant(d_grant), .owner_id(d_owner), .locked(d_locked), .viol(d_viol),
    .fail_cnt(d_fail), .o_dbg_state(d_state)
  );

  // Vector table
  typedef struct {
    string      name;
    logic       rn, rq, wr, rl;
    logic [2:0] id;
    logic [7:0] din;
    logic [7:0] e_dout;
    logic       e_grant;
    logic [2:0] e_owner;
    logic       e_locked, e_viol;
    logic [1:0] e_fc;
  } vec_t;

  vec_t tbl[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic add(input string nm, input logic rn, input logic rq,
                     input logic [2:0] id, input logic wr, input logic rl,
                     input logic [7:0] din, input logic [7:0] ed,
                     input logic eg, input logic [2:0] eo, input logic el,
                     input logic ev, input logic [1:0] ef);
    vec_t v;
    v.name = nm; v.rn = rn; v.rq = rq; v.id = id; v.wr = wr; v.rl = rl;
    v.din = din; v.e_dout = ed; v.e_grant = eg; v.e_owner = eo;
    v.e_locked = el; v.e_viol = ev; v.e_fc = ef;
    tbl.push_back(v);
  endtask

  // Idle-input rows with a fixed expected output
  task automatic add_idle(input string nm, input int n, input logic [7:0] ed,
                          input logic eg, input logic [2:0] eo, input logic el,
                          input logic [1:0] ef);
    for (int k = 0; k < n; k++) add(nm, 1, 0, 0, 0, 0, 8'h00, ed, eg, eo, el, 0, ef);
  endtask

  // Scoreboard compare
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Driver: apply one vector, sample #1 after the edge, compare every output
  task automatic drive(input vec_t v);
    logic [1:0] e_st;
    @(negedge clk);
    rst_n = v.rn; req_valid = v.rq; usr_id = v.id; wr_en = v.wr;
    rel = v.rl; data_in = v.din;
    @(posedge clk);
    #1;
    e_st = v.e_locked ? 2'd2 : (v.e_grant ? 2'd1 : 2'd0);
    chk({v.name, ".data_out"}, 32'(data_out), 32'(v.e_dout));
    chk({v.name, ".grant"},    32'(grant),    32'(v.e_grant));
    chk({v.name, ".owner_id"}, 32'(owner_id), 32'(v.e_owner));
    chk({v.name, ".locked"},   32'(locked),   32'(v.e_locked));
    chk({v.name, ".viol"},     32'(viol),     32'(v.e_viol));
    chk({v.name, ".fail_cnt"}, 32'(fail_cnt), 32'(v.e_fc));
    chk({v.name, ".state"},    32'(dbg_state), 32'(e_st));
  endtask

  // Degenerate-DUT step
  task automatic d_step(input string nm, input logic rn, input logic rq,
                        input logic [2:0] id, input logic wr, input logic [7:0] din,
                        input logic [7:0] ed, input logic eg, input logic [2:0] eo,
                        input logic ev);
    @(negedge clk);
    d_rst_n = rn; d_req = rq; d_id = id; d_wr = wr; d_rel = 1'b0; d_din = din;
    @(posedge clk);
    #1;
    chk({nm, ".data_out"}, 32'(d_dout),  32'(ed));
    chk({nm, ".grant"},    32'(d_grant), 32'(eg));
    chk({nm, ".owner_id"}, 32'(d_owner), 32'(eo));
    chk({nm, ".viol"},     32'(d_viol),  32'(ev));
  endtask

  initial begin
    vec_t v;
    logic exp_auth;

    // Reset state
    add("rst0", 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0);
    add("rst1", 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0);

    // Grant, owner write, 8-cycle session expiry
    add("t1_req", 1, 1, 4, 0, 0, 8'h00, 8'h00, 1, 4, 0, 0, 0);
    add("t1_wr",  1, 0, 4, 1, 0, 8'hA5, 8'hA5, 1, 4, 0, 0, 0);
    add_idle("t1_hold", 6, 8'hA5, 1, 4, 0, 0);
    add_idle("t1_exp",  1, 8'hA5, 0, 0, 0, 0);

    // Non-owner write/release rejected, requests in GRANTED ignored, owner release
    add("t2_req",    1, 1, 6, 0, 0, 8'h00, 8'hA5, 1, 6, 0, 0, 0);
    add("t2_badwr",  1, 0, 4, 1, 0, 8'h3C, 8'hA5, 1, 6, 0, 1, 0);
    add("t2_vclr",   1, 0, 0, 0, 0, 8'h00, 8'hA5, 1, 6, 0, 0, 0);
    add("t2_badrel", 1, 0, 4, 0, 1, 8'h00, 8'hA5, 1, 6, 0, 1, 0);
    add("t2_req4",   1, 1, 4, 0, 0, 8'h00, 8'hA5, 1, 6, 0, 0, 0);
    add("t2_req1",   1, 1, 1, 0, 0, 8'h00, 8'hA5, 1, 6, 0, 0, 0);
    add("t2_rel",    1, 0, 6, 0, 1, 8'h00, 8'hA5, 0, 0, 0, 0, 0);

    // Write in IDLE, fail counter cleared by a grant, two denials do not lock
    add("t4_idlewr", 1, 0, 4, 1, 0, 8'h11, 8'hA5, 0, 0, 0, 1, 0);
    add("t4_d1",     1, 1, 1, 0, 0, 8'h00, 8'hA5, 0, 0, 0, 0, 1);
    add("t4_d2",     1, 1, 2, 0, 0, 8'h00, 8'hA5, 0, 0, 0, 0, 2);
    add("t4_ok",     1, 1, 4, 0, 0, 8'h00, 8'hA5, 1, 4, 0, 0, 0);
    add("t4_rel",    1, 0, 4, 0, 1, 8'h00, 8'hA5, 0, 0, 0, 0, 0);
    add("t4_d3",     1, 1, 0, 0, 0, 8'h00, 8'hA5, 0, 0, 0, 0, 1);
    add("t4_d4",     1, 1, 7, 0, 0, 8'h00, 8'hA5, 0, 0, 0, 0, 2);
    add("t4_ok2",    1, 1, 6, 0, 0, 8'h00, 8'hA5, 1, 6, 0, 0, 0);
    add("t4_rel2",   1, 0, 6, 0, 1, 8'h00, 8'hA5, 0, 0, 0, 0, 0);

    // Lockout after three denials, 16 locked cycles, then grant again
    add("t3_d1",    1, 1, 1, 0, 0, 8'h00, 8'hA5, 0, 0, 0, 0, 1);
    add("t3_d2",    1, 1, 1, 0, 0, 8'h00, 8'hA5, 0, 0, 0, 0, 2);
    add("t3_lock",  1, 1, 1, 0, 0, 8'h00, 8'hA5, 0, 0, 1, 0, 3);
    add("t3_req4",  1, 1, 4, 0, 0, 8'h00, 8'hA5, 0, 0, 1, 0, 3);
    add("t3_wr",    1, 0, 4, 1, 0, 8'h11, 8'hA5, 0, 0, 1, 1, 3);
    add("t3_rel",   1, 0, 4, 0, 1, 8'h00, 8'hA5, 0, 0, 1, 0, 3);
    add_idle("t3_hold", 12, 8'hA5, 0, 0, 1, 3);
    add_idle("t3_unlock", 1, 8'hA5, 0, 0, 0, 0);
    add("t3_req",   1, 1, 4, 0, 0, 8'h00, 8'hA5, 1, 4, 0, 0, 0);
    add("t3_rel2",  1, 0, 4, 0, 1, 8'h00, 8'hA5, 0, 0, 0, 0, 0);

    // Write together with rel, and write in the final session cycle
    add("t5_req6",  1, 1, 6, 0, 0, 8'h00, 8'hA5, 1, 6, 0, 0, 0);
    add("t5_wrrel", 1, 0, 6, 1, 1, 8'h5A, 8'h5A, 0, 0, 0, 0, 0);
    add("t5_req4",  1, 1, 4, 0, 0, 8'h00, 8'h5A, 1, 4, 0, 0, 0);
    add_idle("t5_hold", 7, 8'h5A, 1, 4, 0, 0);
    add("t5_lastwr", 1, 0, 4, 1, 0, 8'hC3, 8'hC3, 0, 0, 0, 0, 0);
    add("t5_latewr", 1, 0, 4, 1, 0, 8'h77, 8'hC3, 0, 0, 0, 1, 0);

    // Reset mid-session (with a write) and mid-lockout
    add("t6_req",    1, 1, 4, 0, 0, 8'h00, 8'hC3, 1, 4, 0, 0, 0);
    add("t6_wr",     1, 0, 4, 1, 0, 8'h99, 8'h99, 1, 4, 0, 0, 0);
    add("t6_rst_s",  0, 0, 4, 1, 0, 8'h42, 8'h00, 0, 0, 0, 0, 0);
    add("t6_post_s", 1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0);
    add("t6_d1",     1, 1, 1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 1);
    add("t6_d2",     1, 1, 1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 2);
    add("t6_lock",   1, 1, 1, 0, 0, 8'h00, 8'h00, 0, 0, 1, 0, 3);
    add("t6_inlock", 1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 1, 0, 3);
    add("t6_rst_l",  0, 1, 4, 1, 0, 8'h42, 8'h00, 0, 0, 0, 0, 0);
    add("t6_post_l", 1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0);
    add("t6_req",    1, 1, 4, 0, 0, 8'h00, 8'h00, 1, 4, 0, 0, 0);
    add("t6_wr2",    1, 0, 4, 1, 0, 8'hE7, 8'hE7, 1, 4, 0, 0, 0);

    foreach (tbl[i]) drive(tbl[i]);

    // Allow-list sweep from a fresh IDLE for every ID
    for (int i = 0; i < 8; i++) begin
      exp_auth = user_grant_pkg::is_authorised(32'(i), 256'(AUTH), 2, 3);
      add("sw_rst", 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0);
      drive(tbl[tbl.size()-1]);
      v.name = $sformatf("sweep_id%0d", i);
      v.rn = 1; v.rq = 1; v.id = 3'(i); v.wr = 0; v.rl = 0; v.din = 8'h00;
      v.e_dout = 8'h00; v.e_grant = exp_auth; v.e_owner = exp_auth ? 3'(i) : 3'd0;
      v.e_locked = 0; v.e_viol = 0; v.e_fc = exp_auth ? 2'd0 : 2'd1;
      drive(v);
    end

    // One-cycle session: exactly one write-capable cycle
    d_step("s1_rst",    0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0);
    d_step("s1_idle",   1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0);
    d_step("s1_req",    1, 1, 6, 0, 8'h00, 8'h00, 1, 6, 0);
    d_step("s1_wr",     1, 0, 6, 1, 8'h81, 8'h81, 0, 0, 0);
    d_step("s1_req2",   1, 1, 4, 0, 8'h00, 8'h81, 1, 4, 0);
    d_step("s1_exp",    1, 0, 0, 0, 8'h00, 8'h81, 0, 0, 0);
    d_step("s1_latewr", 1, 0, 4, 1, 8'h33, 8'h81, 0, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global guard so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
